clk_divider_multi: RTL

- Parametrised, multi-channel successor to the single-channel toggle divider.
- Generates NUM_CH independent divided clocks from clk_in. Each channel has a divisor that can be reprogrammed at runtime, a per-channel enable, and a one-cycle tick pulse on every output edge.
- Sits between the board clock and the countdown timer, display-scan and debounce logic. One instance replaces several fixed dividers.

---
 rtl/clk_div_pkg.sv | 8 +
 rtl/clk_div_if.sv | 28 ++
 rtl/clk_div_channel.sv | 87 ++++++++
 rtl/clk_divider_multi.sv | 46 ++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider: default widths,
// reset divisor and channel-index sizing.
package clk_div_pkg;
  localparam int CNT_W_DEF       = 33;
  localparam int DEFAULT_DIV_DEF = 50000;
  localparam int MAX_CH          = 8;
  localparam int LOAD_CH_W       = 3;
endpackage

// File: rtl/clk_div_if.sv
// Control/status bundle of the multi-channel divider. Load handshake: a load
// transfers on any cycle where load_valid && load_ready are both high.
interface clk_div_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF
);
  logic [NUM_CH-1:0]    ch_en;
  logic                 sync_clr;
  logic                 load_valid;
  logic [LOAD_CH_W-1:0] load_ch;
  logic [CNT_W-1:0]     load_div;
  logic                 load_ready;
  logic [NUM_CH-1:0]    pending;
  logic [NUM_CH-1:0]    divided_clk;
  logic [NUM_CH-1:0]    tick;

  modport master (
    output ch_en, sync_clr, load_valid, load_ch, load_div,
    input  load_ready, pending, divided_clk, tick
  );

  modport slave (
    input  ch_en, sync_clr, load_valid, load_ch, load_div,
    output load_ready, pending, divided_clk, tick
  );
endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: toggle counter with a shadowed divisor that is adopted
// only at a wrap (or immediately when idle/cleared) so no runt half-period occurs.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load_stb,
  input  logic [CNT_W-1:0] load_val,
  output logic             pending,
  output logic             divided_clk,
  output logic             tick
);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             terminal;

  assign terminal = (cnt_q == div_q);

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;
    if (clr) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (pending_q) div_d = shadow_q;
      pending_d = 1'b0;
    end else if (en) begin
      if (terminal) begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        tick_d = 1'b1;
        if (pending_q) begin
          div_d     = shadow_q;
          pending_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pending_q) begin
      div_d     = shadow_q;
      pending_d = 1'b0;
    end
    // A new load lands after any apply above, so it always stays pending.
    if (load_stb) begin
      shadow_d  = load_val;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_q     <= DIV_RST;
      shadow_q  <= DIV_RST;
      pending_q <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end

  assign pending     = pending_q;
  assign divided_clk = clk_q;
  assign tick        = tick_q;
endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel runtime-programmable clock divider: decodes divisor loads to
// channels and instantiates one clk_div_channel per output.
module clk_divider_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic      clk_in,
  input  logic      rst_n,
  clk_div_if.slave  bus
);
  logic [NUM_CH-1:0] load_stb;
  logic [NUM_CH-1:0] pend_w;
  logic [NUM_CH-1:0] dclk_w;
  logic [NUM_CH-1:0] tick_w;
  logic              load_acc;

  assign bus.load_ready = 1'b1;
  assign load_acc       = bus.load_valid && bus.load_ready;

  // Out-of-range indices match no channel, so such loads vanish.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load_stb[i] = load_acc && (bus.load_ch == LOAD_CH_W'(i));

    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .en          (bus.ch_en[i]),
      .clr         (bus.sync_clr),
      .load_stb    (load_stb[i]),
      .load_val    (bus.load_div),
      .pending     (pend_w[i]),
      .divided_clk (dclk_w[i]),
      .tick        (tick_w[i])
    );
  end

  assign bus.pending     = pend_w;
  assign bus.divided_clk = dclk_w;
  assign bus.tick        = tick_w;
endmodule
